// File: rtl/ddr3_top_ex_lfsr8_checker_if.sv
// Read-back beat bus feeding the LFSR checker: one byte per cycle when valid.
interface ddr3_top_ex_lfsr8_checker_if;
    logic       valid;
    logic [7:0] rdata;

    modport master (output valid, output rdata);
    modport slave  (input  valid, input  rdata);
endinterface

// File: rtl/ddr3_top_ex_lfsr8_checker.sv
// Read-data checker for the DDR3 example driver's 8-bit LFSR pattern.
// Regenerates the expected byte stream locally, flags, counts and captures mismatches.
//
// state  | meaning
// IDLE   | disabled, expected held at seed, beats ignored
// HUNT   | self-sync: next valid beat seeds the expected sequence (not compared)
// LOCKED | every valid beat is compared against expected
module ddr3_top_ex_lfsr8_checker #(
    parameter int seed        = 32,
    parameter int SELF_SYNC   = 0,
    parameter int LOSS_THRESH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              resync,
    input  logic                              clear_counts,
    ddr3_top_ex_lfsr8_checker_if.slave        rd,
    output logic                              locked,
    output logic                              error,
    output logic [15:0]                       err_count,
    output logic [31:0]                       beat_count,
    output logic                              first_err_valid,
    output logic [7:0]                        first_err_syndrome
);

    localparam logic [7:0] SEED8      = seed[7:0];
    localparam logic [3:0] LOSS_LIMIT = 4'(LOSS_THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  expected_q, expected_d;
    logic [3:0]  consec_q, consec_d;
    logic [3:0]  consec_inc;
    logic        compare;
    logic        mismatch;

    logic [31:0] beat_base, beat_d;
    logic [15:0] err_base, err_d;
    logic        fev_base, fev_d;
    logic [7:0]  syn_base, syn_d;

    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6], d[5], d[4], d[3] ^ d[7], d[2] ^ d[7], d[1] ^ d[7], d[0], d[7]};
    endfunction

    assign consec_inc = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
    assign mismatch   = compare && (rd.rdata != expected_q);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        consec_d   = consec_q;
        compare    = 1'b0;
        if (!enable) begin
            state_d    = IDLE;
            expected_d = SEED8;
            consec_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = (SELF_SYNC != 0) ? HUNT : LOCKED;
                end
                HUNT: begin
                    if (resync) begin
                        consec_d = '0;
                    end else if (rd.valid) begin
                        expected_d = lfsr_next(rd.rdata);
                        consec_d   = '0;
                        state_d    = LOCKED;
                    end
                end
                LOCKED: begin
                    if (resync) begin
                        consec_d = '0;
                        if (SELF_SYNC != 0) state_d = HUNT;
                        else                expected_d = SEED8;
                    end else if (rd.valid) begin
                        compare = 1'b1;
                        // Advance even on a miss so single bit flips do not desync.
                        expected_d = lfsr_next(expected_q);
                        if (rd.rdata != expected_q) begin
                            consec_d = consec_inc;
                            // Clear the run on loss so a relock starts with a fresh budget.
                            if ((SELF_SYNC != 0) && (consec_inc >= LOSS_LIMIT)) begin
                                state_d  = HUNT;
                                consec_d = '0;
                            end
                        end else begin
                            consec_d = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A clear and a coincident compared beat combine: the beat lands on zeroed counters.
    always_comb begin
        beat_base = clear_counts ? 32'd0 : beat_count;
        err_base  = clear_counts ? 16'd0 : err_count;
        fev_base  = clear_counts ? 1'b0  : first_err_valid;
        syn_base  = clear_counts ? 8'd0  : first_err_syndrome;
        beat_d    = beat_base + {31'd0, compare};
        err_d     = err_base;
        fev_d     = fev_base;
        syn_d     = syn_base;
        if (mismatch && (err_base != 16'hFFFF)) err_d = err_base + 16'd1;
        if (mismatch && !fev_base) begin
            fev_d = 1'b1;
            syn_d = rd.rdata ^ expected_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            expected_q         <= SEED8;
            consec_q           <= '0;
            error              <= 1'b0;
            err_count          <= '0;
            beat_count         <= '0;
            first_err_valid    <= 1'b0;
            first_err_syndrome <= '0;
        end else begin
            state_q            <= state_d;
            expected_q         <= expected_d;
            consec_q           <= consec_d;
            error              <= mismatch;
            err_count          <= err_d;
            beat_count         <= beat_d;
            first_err_valid    <= fev_d;
            first_err_syndrome <= syn_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_ddr3_top_ex_lfsr8_checker.sv
// Directed bench for the LFSR read-data checker: seeded instance (A) and self-sync instance (B).
module tb_ddr3_top_ex_lfsr8_checker;

    typedef struct {
        bit          en;
        bit          v;
        bit          rs;
        bit          clr;
        logic [7:0]  d;
        bit          lk;
        bit          er;
        logic [15:0] ec;
        logic [31:0] bc;
        bit          fv;
        logic [7:0]  sy;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        en_a, rs_a, clr_a, locked_a, error_a, fev_a;
    logic [15:0] ec_a;
    logic [31:0] bc_a;
    logic [7:0]  sy_a;
    logic        en_b, rs_b, clr_b, locked_b, error_b, fev_b;
    logic [15:0] ec_b;
    logic [31:0] bc_b;
    logic [7:0]  sy_b;

    ddr3_top_ex_lfsr8_checker_if bus_a();
    ddr3_top_ex_lfsr8_checker_if bus_b();

    ddr3_top_ex_lfsr8_checker #(.seed(32), .SELF_SYNC(0), .LOSS_THRESH(4)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .resync(rs_a), .clear_counts(clr_a),
        .rd(bus_a), .locked(locked_a), .error(error_a), .err_count(ec_a),
        .beat_count(bc_a), .first_err_valid(fev_a), .first_err_syndrome(sy_a)
    );

    ddr3_top_ex_lfsr8_checker #(.seed(32), .SELF_SYNC(1), .LOSS_THRESH(4)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .resync(rs_b), .clear_counts(clr_b),
        .rd(bus_b), .locked(locked_b), .error(error_b), .err_count(ec_b),
        .beat_count(bc_b), .first_err_valid(fev_b), .first_err_syndrome(sy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int en, input int v, input int rs, input int clr, input int d,
                                input int lk, input int er, input int ec, input int bc,
                                input int fv, input int sy);
        vec_t r;
        r.en = (en != 0); r.v = (v != 0); r.rs = (rs != 0); r.clr = (clr != 0);
        r.d  = 8'(d);
        r.lk = (lk != 0); r.er = (er != 0);
        r.ec = 16'(ec); r.bc = 32'(bc);
        r.fv = (fv != 0); r.sy = 8'(sy);
        return r;
    endfunction

    task automatic check_outs(input bit sel, input string tag, input vec_t v);
        logic [31:0] lk, er, ec, bc, fv, sy;
        if (!sel) begin
            lk = {31'd0, locked_a}; er = {31'd0, error_a}; ec = {16'd0, ec_a};
            bc = bc_a; fv = {31'd0, fev_a}; sy = {24'd0, sy_a};
        end else begin
            lk = {31'd0, locked_b}; er = {31'd0, error_b}; ec = {16'd0, ec_b};
            bc = bc_b; fv = {31'd0, fev_b}; sy = {24'd0, sy_b};
        end
        check({tag, " locked"},     lk, {31'd0, v.lk});
        check({tag, " error"},      er, {31'd0, v.er});
        check({tag, " err_count"},  ec, {16'd0, v.ec});
        check({tag, " beat_count"}, bc, v.bc);
        check({tag, " first_err_valid"},    fv, {31'd0, v.fv});
        check({tag, " first_err_syndrome"}, sy, {24'd0, v.sy});
    endtask

    // Called at a falling edge: drive, let one rising edge pass, compare.
    task automatic run_vec(input bit sel, input vec_t v, input string tag);
        if (!sel) begin
            en_a = v.en; rs_a = v.rs; clr_a = v.clr; bus_a.valid = v.v; bus_a.rdata = v.d;
        end else begin
            en_b = v.en; rs_b = v.rs; clr_b = v.clr; bus_b.valid = v.v; bus_b.rdata = v.d;
        end
        @(negedge clk);
        check_outs(sel, tag, v);
    endtask

    vec_t tab_a[$];
    vec_t tab_b[$];
    vec_t zero_v;

    initial begin
        // en v rs clr data | locked error err_count beat_count fev syndrome
        tab_a.push_back(mk(1,0,0,0,'h00, 1,0,0,0,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h20, 1,0,0,1,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h40, 1,0,0,2,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h80, 1,0,0,3,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h1D, 1,0,0,4,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h3A, 1,0,0,5,0,'h00));
        tab_a.push_back(mk(1,0,1,1,'h00, 1,0,0,0,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h20, 1,0,0,1,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h40, 1,0,0,2,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h81, 1,1,1,3,1,'h01));
        tab_a.push_back(mk(1,1,0,0,'h1D, 1,0,1,4,1,'h01));
        tab_a.push_back(mk(1,1,0,0,'h3A, 1,0,1,5,1,'h01));
        tab_a.push_back(mk(1,0,0,0,'h00, 1,0,1,5,1,'h01));
        tab_a.push_back(mk(1,1,0,0,'h74, 1,0,1,6,1,'h01));
        tab_a.push_back(mk(1,1,1,0,'h20, 1,0,1,6,1,'h01));
        tab_a.push_back(mk(1,1,0,0,'h20, 1,0,1,7,1,'h01));
        tab_a.push_back(mk(1,1,0,1,'hFF, 1,1,1,1,1,'hBF));
        tab_a.push_back(mk(1,0,0,1,'h00, 1,0,0,0,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h80, 1,0,0,1,0,'h00));
        tab_a.push_back(mk(0,0,0,0,'h00, 0,0,0,1,0,'h00));
        tab_a.push_back(mk(0,1,0,0,'h55, 0,0,0,1,0,'h00));
        tab_a.push_back(mk(1,0,0,0,'h00, 1,0,0,1,0,'h00));
        tab_a.push_back(mk(1,1,0,0,'h20, 1,0,0,2,0,'h00));

        tab_b.push_back(mk(1,0,0,0,'h00, 0,0,0,0,0,'h00));
        tab_b.push_back(mk(1,1,0,0,'h1D, 1,0,0,0,0,'h00));
        tab_b.push_back(mk(1,1,0,0,'h3A, 1,0,0,1,0,'h00));
        tab_b.push_back(mk(1,1,0,0,'h74, 1,0,0,2,0,'h00));
        tab_b.push_back(mk(1,1,0,0,'h00, 1,1,1,3,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h00, 1,1,2,4,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h00, 1,1,3,5,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h13, 1,0,3,6,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h00, 1,1,4,7,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h00, 1,1,5,8,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h00, 1,1,6,9,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h00, 0,1,7,10,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h40, 1,0,7,10,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h80, 1,0,7,11,1,'hE8));
        tab_b.push_back(mk(1,1,1,0,'h1D, 0,0,7,11,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h3A, 1,0,7,11,1,'hE8));
        tab_b.push_back(mk(1,1,0,0,'h74, 1,0,7,12,1,'hE8));

        zero_v = mk(0,0,0,0,0, 0,0,0,0,0,0);

        reset = 1'b1;
        en_a = 1'b0; rs_a = 1'b0; clr_a = 1'b0; bus_a.valid = 1'b0; bus_a.rdata = 8'h00;
        en_b = 1'b0; rs_b = 1'b0; clr_b = 1'b0; bus_b.valid = 1'b0; bus_b.rdata = 8'h00;
        repeat (2) @(negedge clk);
        check_outs(1'b0, "reset A", zero_v);
        check_outs(1'b1, "reset B", zero_v);
        reset = 1'b0;
        @(negedge clk);
        check_outs(1'b0, "idle A", zero_v);

        for (int i = 0; i < tab_a.size(); i++)
            run_vec(1'b0, tab_a[i], $sformatf("A[%0d]", i));
        bus_a.valid = 1'b0;

        for (int i = 0; i < tab_b.size(); i++)
            run_vec(1'b1, tab_b[i], $sformatf("B[%0d]", i));
        bus_b.valid = 1'b0;

        // Saturation: 0x00 never matches a nonzero LFSR state, so every beat is a miss.
        run_vec(1'b0, mk(1,0,1,1,'h00, 1,0,0,0,0,'h00), "sat start");
        en_a = 1'b1; rs_a = 1'b0; clr_a = 1'b0; bus_a.valid = 1'b1; bus_a.rdata = 8'h00;
        repeat (65534) @(negedge clk);
        check_outs(1'b0, "sat FFFE", mk(1,1,0,0,0, 1,1,'hFFFE,65534,1,'h20));
        for (int i = 1; i <= 3; i++)
            run_vec(1'b0, mk(1,1,0,0,'h00, 1,1,'hFFFF,65534 + i,1,'h20), $sformatf("sat hold %0d", i));
        run_vec(1'b0, mk(1,0,1,0,'h00, 1,0,'hFFFF,65537,1,'h20), "sat resync");
        run_vec(1'b0, mk(1,1,0,1,'h20, 1,0,0,1,0,'h00), "clear with beat");

        // Asynchronous reset in the middle of a beat, checked before the next rising edge.
        en_a = 1'b1; rs_a = 1'b0; clr_a = 1'b0; bus_a.valid = 1'b1; bus_a.rdata = 8'h40;
        #2 reset = 1'b1;
        #1;
        check_outs(1'b0, "async reset A", zero_v);
        check_outs(1'b1, "async reset B", zero_v);
        @(negedge clk);
        reset = 1'b0;
        run_vec(1'b0, mk(1,0,0,0,'h00, 1,0,0,0,0,'h00), "post-reset enable");
        run_vec(1'b0, mk(1,1,0,0,'h20, 1,0,0,1,0,'h00), "post-reset seed");
        run_vec(1'b0, mk(1,1,0,0,'h40, 1,0,0,2,0,'h00), "post-reset next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_top_ex_lfsr8_checker.md
Name: ddr3_top_ex_lfsr8_checker

Overview:
Read-data checker for the DDR3 example driver's 8-bit LFSR pattern. It consumes byte beats read back from memory and regenerates the expected sequence locally, using the same polynomial and seed as the pattern generator. It flags mismatches, counts beats and errors, and captures the first failing syndrome. Self-sync mode lets it lock onto a stream without a known start point.

Parameters:
seed, 32, starting expected value (low 8 bits used) in seeded mode and after enable rises
SELF_SYNC, 0, 0 = expected starts at seed; 1 = hunt and lock from the first valid beat
LOSS_THRESH, 4, consecutive mismatches in LOCKED that return the block to HUNT (SELF_SYNC=1 only); range 1..15

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  0 forces IDLE and reloads seed; 1 enables checking
valid  input  1  rdata beat present this cycle
rdata  input  8  read-back byte
resync  input  1  one-cycle request: re-hunt (SELF_SYNC=1) or reload seed (SELF_SYNC=0)
clear_counts  input  1  synchronous clear of beat_count, err_count, first_err_*
locked  output  1  checker is comparing against a valid expected sequence
error  output  1  one-cycle pulse, a compared beat mismatched
err_count  output  16  mismatched beats, saturates at 16'hFFFF
beat_count  output  32  compared beats, wraps modulo 2^32
first_err_valid  output  1  first_err_syndrome holds a capture
first_err_syndrome  output  8  rdata XOR expected of first mismatch since clear

Behaviour:
- Next-state function N(d), where d is the 8-bit value: n0=d7, n1=d0, n2=d1^d7, n3=d2^d7, n4=d3^d7, n5=d4, n6=d5, n7=d6. This is identical to the pattern generator.
- Reset: state=IDLE, expected=seed[7:0], all outputs 0.
- State IDLE (enable=0): expected<=seed[7:0], locked=0, consec_err=0. Beats are ignored. On enable=1, go to LOCKED if SELF_SYNC=0, otherwise go to HUNT.
- State HUNT: locked=0. On valid, expected<=N(rdata) and state goes to LOCKED. The hunt beat is not compared and not counted.
- State LOCKED: locked=1. On valid:
  - Compare rdata with expected. beat_count+1.
  - Match: consec_err<=0.
  - Mismatch: error=1 on the next cycle (registered, latency 1). err_count+1 unless saturated, consec_err+1.
  - If first_err_valid=0: first_err_syndrome<=rdata^expected and first_err_valid<=1.
  - expected<=N(expected) whether the beat matched or not, so isolated bit errors do not desync the checker.
- Loss of lock (SELF_SYNC=1): a mismatch that makes consec_err reach LOSS_THRESH moves the block to HUNT. That beat is still counted and flagged. With SELF_SYNC=0, lock is never lost.
- No valid means expected holds, equivalent to a generator pause.
- resync (enable=1):
  - SELF_SYNC=1: go to HUNT.
  - SELF_SYNC=0: expected<=seed[7:0], stay LOCKED.
  - In both cases consec_err<=0, and a coincident beat is discarded (not compared, not counted).
- clear_counts: zeroes beat_count, err_count and first_err_valid. A beat compared in the same cycle is applied after the clear, giving count 1 and a capture if it mismatched.
- Priority: reset > enable=0 > resync > valid beat. clear_counts is independent of the others.
- enable falling mid-stream: goes to IDLE on the next edge. Counters keep their values.
- Reset mid-operation: everything returns to reset values immediately (asynchronously).
- Outputs are registered; locked reflects the state register.

Test Plan:
- Seeded, clean: SELF_SYNC=0, enable=1, beats 0x20,0x40,0x80,0x1D,0x3A -> error never asserted, beat_count=5, err_count=0, locked=1.
- Single error: same stream with the 3rd beat 0x81 -> one error pulse one cycle after that beat, err_count=1, syndrome=0x01, later beats match.
- Self-sync: SELF_SYNC=1, beats 0x1D,0x3A,0x74 -> locked after the first beat, beat_count=2, err_count=0.
- Loss of lock: SELF_SYNC=1, locked, then 4 beats of 0x00 -> 4 error pulses, state returns to HUNT (locked=0), next beat 0x40 relocks, following 0x80 matches.
- Saturation and clear: force err_count to 0xFFFE, inject 3 mismatches -> 0xFFFF held. Then clear_counts together with a matching beat -> err_count=0, beat_count=1, first_err_valid=0.
- Priority and reset: resync and valid in the same cycle -> beat not counted. reset asserted mid-stream -> all outputs 0 at once, and expected is 0x20 after release.
